// File: rtl/cache_miss_ctrl.sv
// rtl/cache_miss_ctrl.sv - miss sequencing controller for the read-only set-associative cache
// Owns the per-set block_info shadow and round-robin pointers; runs an invalidate sweep after reset.

package cache_pkg;
  localparam int NumSets       = 4;
  localparam int Associativity = 2;
  localparam int TagWidth      = 4;
  localparam int DataWidth     = 8;
  localparam int SetWidth      = (NumSets > 1) ? $clog2(NumSets) : 1;
  localparam int WayWidth      = (Associativity > 1) ? $clog2(Associativity) : 1;

  typedef struct packed {
    logic                valid;
    logic [TagWidth-1:0] tag;
  } block_info_t;

  localparam int InfoW = $bits(block_info_t);

  typedef block_info_t [Associativity-1:0] set_info_t;
endpackage

module cache_miss_ctrl
  import cache_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [SetWidth-1:0]            req_set_i,
  input  logic [TagWidth-1:0]            req_tag_i,
  output logic                           resp_valid_o,
  output logic [DataWidth-1:0]           resp_data_o,
  output logic [SetWidth-1:0]            cache_read_set_o,
  output logic [TagWidth-1:0]            cache_read_tag_o,
  input  logic                           cache_read_hit_i,
  input  logic [DataWidth-1:0]           cache_read_data_i,
  output logic                           cache_we_o,
  output logic [SetWidth-1:0]            cache_wset_o,
  output logic [Associativity*InfoW-1:0] cache_winfo_o,
  output logic [WayWidth-1:0]            cache_wway_o,
  output logic [DataWidth-1:0]           cache_wdata_o,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic [TagWidth+SetWidth-1:0]   mem_req_addr_o,
  input  logic                           mem_resp_valid_i,
  input  logic [DataWidth-1:0]           mem_resp_data_i
);

  localparam logic [2:0] INIT   = 3'd0;
  localparam logic [2:0] IDLE   = 3'd1;
  localparam logic [2:0] LOOKUP = 3'd2;
  localparam logic [2:0] MREQ   = 3'd3;
  localparam logic [2:0] MWAIT  = 3'd4;
  localparam logic [2:0] FILL   = 3'd5;

  logic [2:0]           state_q;
  logic [SetWidth-1:0]  init_cnt_q;
  logic [SetWidth-1:0]  set_q;
  logic [TagWidth-1:0]  tag_q;
  logic [DataWidth-1:0] data_q;
  set_info_t            shadow_q [NumSets];
  logic [WayWidth-1:0]  rr_q     [NumSets];

  set_info_t            cur_info;
  set_info_t            new_info;
  logic [WayWidth-1:0]  victim;
  logic [WayWidth-1:0]  victim_next;
  logic                 any_invalid;

  // Lowest-index invalid way wins; the RR pointer only matters once the set is full.
  always_comb begin
    cur_info    = shadow_q[set_q];
    victim      = rr_q[set_q];
    any_invalid = 1'b0;
    for (int w = Associativity - 1; w >= 0; w--) begin
      if (!cur_info[w].valid) begin
        victim      = WayWidth'(w);
        any_invalid = 1'b1;
      end
    end
    victim_next = (victim == WayWidth'(Associativity - 1)) ? '0 : victim + 1'b1;
    new_info              = cur_info;
    new_info[victim].valid = 1'b1;
    new_info[victim].tag   = tag_q;
  end

  // Qualifiers are gated by rst_ni so nothing is asserted while reset is held.
  always_comb begin
    req_ready_o     = rst_ni && (state_q == IDLE);
    resp_valid_o    = rst_ni && (((state_q == LOOKUP) && cache_read_hit_i) || (state_q == FILL));
    resp_data_o     = (state_q == FILL) ? data_q : cache_read_data_i;
    cache_we_o      = rst_ni && ((state_q == INIT) || (state_q == FILL));
    cache_wset_o    = (state_q == INIT) ? init_cnt_q : set_q;
    cache_winfo_o   = (state_q == INIT) ? '0 : new_info;
    cache_wway_o    = (state_q == INIT) ? '0 : victim;
    cache_wdata_o   = (state_q == INIT) ? '0 : data_q;
    mem_req_valid_o = rst_ni && (state_q == MREQ);
  end

  assign cache_read_set_o = set_q;
  assign cache_read_tag_o = tag_q;
  assign mem_req_addr_o   = {tag_q, set_q};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      set_q      <= '0;
      tag_q      <= '0;
      data_q     <= '0;
      for (int s = 0; s < NumSets; s++) begin
        shadow_q[s] <= '0;
        rr_q[s]     <= '0;
      end
    end else begin
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == SetWidth'(NumSets - 1)) state_q <= IDLE;
        end
        IDLE: begin
          if (req_valid_i) begin
            set_q   <= req_set_i;
            tag_q   <= req_tag_i;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: state_q <= cache_read_hit_i ? IDLE : MREQ;
        MREQ: begin
          if (mem_req_ready_i) state_q <= MWAIT;
        end
        MWAIT: begin
          if (mem_resp_valid_i) begin
            data_q  <= mem_resp_data_i;
            state_q <= FILL;
          end
        end
        FILL: begin
          shadow_q[set_q] <= new_info;
          if (!any_invalid) rr_q[set_q] <= victim_next;
          state_q <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb/tb_cache_miss_ctrl.sv - scoreboard bench for cache_miss_ctrl with behavioural cache model
module tb_cache_miss_ctrl;

  logic        clk_i;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_set_i;
  logic [3:0]  req_tag_i;
  logic        resp_valid_o;
  logic [7:0]  resp_data_o;
  logic [1:0]  cache_read_set_o;
  logic [3:0]  cache_read_tag_o;
  logic        cache_read_hit_i;
  logic [7:0]  cache_read_data_i;
  logic        cache_we_o;
  logic [1:0]  cache_wset_o;
  logic [9:0]  cache_winfo_o;
  logic [0:0]  cache_wway_o;
  logic [7:0]  cache_wdata_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [5:0]  mem_req_addr_o;
  logic        mem_resp_valid_i;
  logic [7:0]  mem_resp_data_i;

  cache_miss_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_set_i(req_set_i), .req_tag_i(req_tag_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
    .cache_read_set_o(cache_read_set_o), .cache_read_tag_o(cache_read_tag_o),
    .cache_read_hit_i(cache_read_hit_i), .cache_read_data_i(cache_read_data_i),
    .cache_we_o(cache_we_o), .cache_wset_o(cache_wset_o), .cache_winfo_o(cache_winfo_o),
    .cache_wway_o(cache_wway_o), .cache_wdata_o(cache_wdata_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  bit in_init  = 1'b0;

  typedef struct {
    int way;
    int set;
    int tag;
    int data;
  } fill_t;

  int    resp_q [$];
  fill_t fill_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural cache: combinational read, whole-set info replaced on write.
  logic [4:0] m_info [4][2];
  logic [7:0] m_data [4][2];

  initial begin
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++) begin
        m_info[s][w] = '0;
        m_data[s][w] = '0;
      end
  end

  always @(posedge clk_i) begin
    if (cache_we_o) begin
      for (int w = 0; w < 2; w++) m_info[cache_wset_o][w] <= cache_winfo_o[w*5 +: 5];
      m_data[cache_wset_o][cache_wway_o] <= cache_wdata_o;
    end
  end

  always_comb begin
    cache_read_hit_i  = 1'b0;
    cache_read_data_i = '0;
    for (int w = 0; w < 2; w++) begin
      if (m_info[cache_read_set_o][w][4] && (m_info[cache_read_set_o][w][3:0] == cache_read_tag_o)) begin
        cache_read_hit_i  = 1'b1;
        cache_read_data_i = m_data[cache_read_set_o][w];
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (resp_valid_o) begin
        if (resp_q.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
        else check("resp_data", {24'd0, resp_data_o}, resp_q.pop_front());
      end
      if (cache_we_o && !in_init) begin
        if (fill_q.size() == 0) check("fill_unexpected", 32'd1, 32'd0);
        else begin
          fill_t e;
          e = fill_q.pop_front();
          check("fill_way", {31'd0, cache_wway_o}, e.way);
          check("fill_set", {30'd0, cache_wset_o}, e.set);
          check("fill_info", {27'd0, cache_winfo_o[cache_wway_o*5 +: 5]}, 32'h10 | e.tag);
          check("fill_data", {24'd0, cache_wdata_o}, e.data);
        end
      end
    end
  end

  task automatic init_seq(input bit late_resp);
    int we_cnt;
    @(negedge clk_i);
    check("rst_ready", {31'd0, req_ready_o}, 0);
    check("rst_resp", {31'd0, resp_valid_o}, 0);
    check("rst_mreq", {31'd0, mem_req_valid_o}, 0);
    check("rst_we", {31'd0, cache_we_o}, 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    in_init = 1'b1;
    we_cnt  = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_i);
      we_cnt += int'(cache_we_o);
      if (c <= 4) begin
        check("init_wset", {30'd0, cache_wset_o}, c - 1);
        check("init_winfo", {22'd0, cache_winfo_o}, 0);
      end
      check("init_ready", {31'd0, req_ready_o}, (c >= 5) ? 1 : 0);
      if (late_resp && c == 2) begin
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 8'hDD;
      end
      if (c == 3) mem_resp_valid_i = 1'b0;
    end
    in_init = 1'b0;
    check("init_we_cycles", we_cnt, 4);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, {31'd0, req_ready_o}, 1);
  endtask

  task automatic issue(input logic [1:0] s, input logic [3:0] t);
    @(negedge clk_i);
    wait_ready("req_ready");
    req_valid_i = 1'b1;
    req_set_i   = s;
    req_tag_i   = t;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    check("lookup_ready", {31'd0, req_ready_o}, 0);
  endtask

  task automatic mem_handshake(input logic [1:0] s, input logic [3:0] t, input int rdly);
    check("miss_no_resp", {31'd0, resp_valid_o}, 0);
    @(negedge clk_i);
    check("mreq_valid", {31'd0, mem_req_valid_o}, 1);
    check("mreq_addr", {26'd0, mem_req_addr_o}, {26'd0, t, s});
    repeat (rdly) begin
      @(negedge clk_i);
      check("mreq_hold_valid", {31'd0, mem_req_valid_o}, 1);
      check("mreq_hold_addr", {26'd0, mem_req_addr_o}, {26'd0, t, s});
      check("mreq_hold_ready", {31'd0, req_ready_o}, 0);
    end
    mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    mem_req_ready_i = 1'b0;
    check("mreq_drop", {31'd0, mem_req_valid_o}, 0);
  endtask

  task automatic do_req(input logic [1:0] s, input logic [3:0] t, input bit hit,
                        input logic [7:0] d, input int way, input int rdly);
    fill_t f;
    resp_q.push_back(int'(d));
    if (!hit) begin
      f.way = way; f.set = int'(s); f.tag = int'(t); f.data = int'(d);
      fill_q.push_back(f);
    end
    issue(s, t);
    if (hit) begin
      check("hit_latency", {31'd0, resp_valid_o}, 1);
      @(negedge clk_i);
      check("hit_no_mreq", {31'd0, mem_req_valid_o}, 0);
    end else begin
      mem_handshake(s, t, rdly);
      @(negedge clk_i);
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = d;
      @(negedge clk_i);
      mem_resp_valid_i = 1'b0;
    end
    wait_ready("idle_return");
  endtask

  initial begin
    rst_ni           = 1'b0;
    req_valid_i      = 1'b0;
    req_set_i        = '0;
    req_tag_i        = '0;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = '0;
    repeat (2) @(posedge clk_i);

    init_seq(1'b0);
    do_req(2'd1, 4'd3, 1'b0, 8'hAA, 0, 0);
    do_req(2'd1, 4'd3, 1'b1, 8'hAA, 0, 0);
    do_req(2'd1, 4'd5, 1'b0, 8'h55, 1, 0);
    do_req(2'd1, 4'd7, 1'b0, 8'h77, 0, 1);
    do_req(2'd1, 4'd9, 1'b0, 8'h99, 1, 0);
    do_req(2'd1, 4'd3, 1'b0, 8'h33, 0, 2);
    do_req(2'd1, 4'd9, 1'b1, 8'h99, 0, 0);
    do_req(2'd2, 4'd1, 1'b0, 8'h21, 0, 5);

    // Reset lands in MWAIT; both the in-reset and the post-reset responses must be dropped.
    issue(2'd3, 4'd2);
    mem_handshake(2'd3, 4'd2, 0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = 8'hEE;
    check("mid_rst_we", {31'd0, cache_we_o}, 0);
    check("mid_rst_resp", {31'd0, resp_valid_o}, 0);
    @(negedge clk_i);
    mem_resp_valid_i = 1'b0;
    init_seq(1'b1);
    repeat (3) @(negedge clk_i);

    do_req(2'd1, 4'd7, 1'b0, 8'h17, 0, 0);
    do_req(2'd3, 4'd2, 1'b0, 8'h32, 0, 1);
    do_req(2'd3, 4'd2, 1'b1, 8'h32, 0, 0);

    check("resp_q_drained", resp_q.size(), 0);
    check("fill_q_drained", fill_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
